// File: rtl/free_list.sv
// Block-index free list: a circular FIFO of free block indices, backed by an
// allocation bitmap that rejects double frees and out-of-range frees.
package mem_pkg;
   parameter int ADDR_W = 4;
endpackage

module free_list #(
   parameter int ADDR_W     = mem_pkg::ADDR_W,
   parameter int NUM_BLOCKS = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_req_i,
   output logic              alloc_gnt_o,
   output logic [ADDR_W-1:0] alloc_block_idx_o,
   input  logic              free_valid_i,
   input  logic [ADDR_W-1:0] free_block_idx_i,
   output logic [ADDR_W:0]   free_count_o,
   output logic              empty_o,
   output logic              init_done_o,
   output logic              err_o
);
   localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam logic [IW-1:0]   LAST = IW'(NUM_BLOCKS - 1);
   localparam logic [ADDR_W:0] NB   = (ADDR_W + 1)'(NUM_BLOCKS);

   typedef enum logic {INIT, RUN} state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0]     fifo [NUM_BLOCKS];
   logic [IW-1:0]         rd_ptr, wr_ptr;
   logic [ADDR_W:0]       count_q, count_d;
   logic [NUM_BLOCKS-1:0] bitmap_q, bitmap_d;
   logic                  gnt_q, err_q;
   logic [ADDR_W-1:0]     idx_q;

   logic              in_init;
   logic              free_ok;
   logic              do_alloc;
   logic              do_free;
   logic              do_err;
   logic              do_wr;
   logic [ADDR_W-1:0] wr_data;
   logic [ADDR_W-1:0] head;
   logic [IW-1:0]     fidx;

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:    if (wr_ptr == LAST) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      init_done_o       = (state_q == RUN);
      alloc_gnt_o       = gnt_q;
      alloc_block_idx_o = idx_q;
      free_count_o      = count_q;
      empty_o           = (count_q == '0);
      err_o             = err_q;
   end

   // Range check is done at full width so NUM_BLOCKS < 2**ADDR_W is caught.
   always_comb begin
      in_init  = (state_q == INIT);
      head     = fifo[rd_ptr];
      fidx     = free_block_idx_i[IW-1:0];
      free_ok  = ({1'b0, free_block_idx_i} < NB) && bitmap_q[fidx];
      do_alloc = !in_init && alloc_req_i && (count_q != '0);
      do_free  = !in_init && free_valid_i && free_ok;
      do_err   = free_valid_i && (in_init || !free_ok);
      do_wr    = in_init || do_free;
      wr_data  = in_init ? ADDR_W'(wr_ptr) : free_block_idx_i;
   end

   always_comb begin
      count_d = count_q;
      unique case ({do_wr, do_alloc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // A same-edge alloc and free never touch the same bit: the granted
   // block's bit is still clear, so its free was rejected above.
   always_comb begin
      bitmap_d = bitmap_q;
      if (in_init) bitmap_d = '0;
      if (do_alloc) bitmap_d[head[IW-1:0]] = 1'b1;
      if (do_free) bitmap_d[fidx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
         bitmap_q <= '0;
         gnt_q    <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         gnt_q    <= do_alloc;
         err_q    <= do_err;
         count_q  <= count_d;
         bitmap_q <= bitmap_d;
         if (do_alloc) begin
            idx_q  <= head;
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) fifo[wr_ptr] <= wr_data;
   end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter: ADDR_W, default mem_pkg::ADDR_W, block index width.
REQ-002 Parameter: NUM_BLOCKS, default 2**ADDR_W, number of managed blocks; legal range 2..2**ADDR_W.
REQ-003 Port: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: alloc_req_i  input  1  allocation request from the arbiter; level, sampled every cycle.
REQ-006 Port: alloc_gnt_o  output  1  one-cycle grant pulse; alloc_block_idx_o valid in the same cycle.
REQ-007 Port: alloc_block_idx_o  output  ADDR_W  allocated block index.
REQ-008 Port: free_valid_i  input  1  return one block to the pool; single-cycle, always sampled.
REQ-009 Port: free_block_idx_i  input  ADDR_W  index being returned.
REQ-010 Port: free_count_o  output  ADDR_W+1  number of blocks currently free.
REQ-011 Port: empty_o  output  1  free_count_o == 0.
REQ-012 Port: init_done_o  output  1  high once initialisation completes; low during init.
REQ-013 Port: err_o  output  1  one-cycle pulse on a rejected free.

Function
REQ-014 Storage: circular FIFO of NUM_BLOCKS entries (ADDR_W bits each), read pointer, write pointer, free count, plus an NUM_BLOCKS-bit allocated bitmap.
REQ-015 States: INIT, RUN. Reset enters INIT.
REQ-016 INIT: one entry per cycle, FIFO[k] <= k for k = 0..NUM_BLOCKS-1; bitmap cleared; count increments per entry.
REQ-017 INIT -> RUN on the cycle after writing entry NUM_BLOCKS-1; init_done_o goes high on entry to RUN, i.e. exactly NUM_BLOCKS cycles after reset release, with free_count_o == NUM_BLOCKS.
REQ-018 INIT: alloc_req_i ignored (no grant, no queuing); free_valid_i dropped with err_o pulse next cycle.
REQ-019 Allocation: in RUN, alloc_req_i high at edge N and count > 0 -> alloc_gnt_o high during cycle N+1, alloc_block_idx_o = FIFO[rd_ptr], rd_ptr+1, count-1, bitmap bit set.
REQ-020 Back-to-back: alloc_req_i held high grants every cycle until empty; no request memory — a request not granted is not replayed.
REQ-021 Empty: alloc_req_i with count == 0 -> no grant; alloc_block_idx_o holds its last value.
REQ-022 Free: in RUN, free_valid_i at edge N with index < NUM_BLOCKS and bitmap bit set -> FIFO[wr_ptr] <= index, wr_ptr+1, count+1, bitmap bit cleared, visible cycle N+1.
REQ-023 Rejected free: index >= NUM_BLOCKS or bitmap bit clear (double free / never allocated) -> no state change, err_o high during cycle N+1.
REQ-024 Simultaneous alloc and valid free same edge: both performed; count unchanged; allocation reads pre-edge FIFO contents (no bypass), so with count == 0 only the free occurs.
REQ-025 Simultaneous alloc and free of the block being granted the same edge: impossible by bitmap (bit still clear) -> free rejected with err_o.
REQ-026 Pointers wrap modulo NUM_BLOCKS (non-power-of-2 explicitly compared, not truncated).
REQ-027 Order: strict FIFO — after init grants return 0,1,2,...; freed blocks reissued in free order after the initial pool.
REQ-028 free_count_o never exceeds NUM_BLOCKS nor underflows; guaranteed by REQ-021/023.

Reset
REQ-029 rst_n low, at any time including mid-INIT or mid-grant: immediately alloc_gnt_o=0, alloc_block_idx_o=0, free_count_o=0, empty_o=1, init_done_o=0, err_o=0, pointers=0, bitmap cleared, state INIT.
REQ-030 On release: INIT restarts from entry 0; no state survives a reset.

Verification
REQ-031 NUM_BLOCKS=8, release reset, alloc_req_i held high from release -> no grant for 8 cycles; init_done_o high at cycle 8; grants on 8 consecutive cycles with idx 0..7; then empty_o=1, grants stop.
REQ-032 After REQ-031, free 5 then 2 -> free_count_o=2; alloc twice -> idx 5 then 2.
REQ-033 NUM_BLOCKS=8, count=3, alloc_req_i and free_valid_i(idx of an allocated block) same edge -> one grant, free_count_o stays 3.
REQ-034 Free idx 3 twice without reallocation -> first accepted, second gives err_o pulse, count increments once; free idx 9 (ADDR_W=4) -> err_o, no change.
REQ-035 NUM_BLOCKS=6 (non-power-of-2): 20 alloc/free cycles -> pointers wrap at 6, indices always <6, count consistent with a scoreboard model.
REQ-036 Assert rst_n low mid-burst of grants -> alloc_gnt_o low immediately, free_count_o=0; after release full INIT repeats, first grant idx 0.
